// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU control decoder: operation codes,
// ALUOp encodings and the handshake FSM state type.
package alu_pkg;

    localparam int LEGACY_W = 3;
    localparam int CODE_W   = 5;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_RSVD   = 2'b11;

    // M-extension codes are {2'b10, funct3} so the decoder can build them directly
    typedef enum logic [CODE_W-1:0] {
        ALU_ADD    = 5'b00000,
        ALU_SUB    = 5'b00001,
        ALU_AND    = 5'b00010,
        ALU_OR     = 5'b00011,
        ALU_XOR    = 5'b00100,
        ALU_SLT    = 5'b00101,
        ALU_SLTU   = 5'b00110,
        ALU_SLL    = 5'b00111,
        ALU_SRL    = 5'b01000,
        ALU_SRA    = 5'b01001,
        ALU_MUL    = 5'b10000,
        ALU_MULH   = 5'b10001,
        ALU_MULHSU = 5'b10010,
        ALU_MULHU  = 5'b10011,
        ALU_DIV    = 5'b10100,
        ALU_DIVU   = 5'b10101,
        ALU_REM    = 5'b10110,
        ALU_REMU   = 5'b10111
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_VALID = 2'b10
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Pure combinational ALUOp/funct decode into operation code, muldiv route and
// illegal flag. Illegal encodings always decode to ADD with muldiv clear.
import alu_pkg::*;

module alu_op_decode #(
    parameter bit EN_M = 1'b1
) (
    input  logic [1:0]        ALUOp,
    input  logic [2:0]        funct3,
    input  logic              opb5,
    input  logic              funct7b5,
    input  logic              funct7b0,
    output logic [CODE_W-1:0] ctrl,
    output logic              muldiv,
    output logic              illegal
);

    alu_ctrl_e ctrl_s;
    logic      muldiv_s;
    logic      illegal_s;

    // Operation decode from ALUOp and instruction function fields
    always_comb begin
        ctrl_s    = ALU_ADD;
        muldiv_s  = 1'b0;
        illegal_s = 1'b0;
        case (ALUOp)
            ALUOP_ADD: begin
                ctrl_s = ALU_ADD;
            end
            ALUOP_BRANCH: begin
                case (funct3)
                    3'b000, 3'b001: ctrl_s = ALU_SUB;
                    3'b100, 3'b101: ctrl_s = ALU_SLT;
                    3'b110, 3'b111: ctrl_s = ALU_SLTU;
                    default:        illegal_s = 1'b1;
                endcase
            end
            ALUOP_FUNCT: begin
                if (opb5 && funct7b0) begin
                    if (EN_M) begin
                        ctrl_s   = alu_ctrl_e'({2'b10, funct3});
                        muldiv_s = 1'b1;
                    end else begin
                        illegal_s = 1'b1;
                    end
                end else begin
                    case (funct3)
                        3'b000:  ctrl_s = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
                        3'b001:  ctrl_s = ALU_SLL;
                        3'b010:  ctrl_s = ALU_SLT;
                        3'b011:  ctrl_s = ALU_SLTU;
                        3'b100:  ctrl_s = ALU_XOR;
                        // shift-immediates carry funct7b5 too, so SRA/SRL ignores opb5
                        3'b101:  ctrl_s = funct7b5 ? ALU_SRA : ALU_SRL;
                        3'b110:  ctrl_s = ALU_OR;
                        3'b111:  ctrl_s = ALU_AND;
                        default: ctrl_s = ALU_ADD;
                    endcase
                end
            end
            default: begin
                illegal_s = 1'b1;
            end
        endcase
    end

    assign ctrl    = ctrl_s;
    assign muldiv  = muldiv_s;
    assign illegal = illegal_s;

endmodule

// File: rtl/alu_decode_seq.sv
// Registered ALU control decode stage with valid/ready handshakes; holds issue
// while a MUL/DIV occupies the multicycle unit.
import alu_pkg::*;

module alu_decode_seq #(
    parameter int CTRL_W     = 5,
    parameter bit EN_M       = 1'b1,
    parameter int MUL_CYCLES = 3,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              opb5,
    input  logic [2:0]        funct3,
    input  logic              funct7b5,
    input  logic              funct7b0,
    input  logic [1:0]        ALUOp,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] ALUControl,
    output logic              MulDiv,
    output logic              illegal
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

    generate
        if (CTRL_W < 5) begin : g_ctrl_w_chk
            $error("alu_decode_seq: CTRL_W must be >= 5");
        end
        if ((MUL_CYCLES < 1) || (DIV_CYCLES < 1)) begin : g_cyc_chk
            $error("alu_decode_seq: MUL_CYCLES and DIV_CYCLES must be >= 1");
        end
    endgenerate

    state_e             state_r;
    state_e             state_nxt_s;
    state_e             load_state_s;
    logic [CNT_W-1:0]   count_r;
    logic [CNT_W-1:0]   count_nxt_s;
    logic [CNT_W-1:0]   load_cnt_s;
    logic               in_ready_s;
    logic               accept_s;
    logic [CODE_W-1:0]  dec_ctrl_s;
    logic               dec_muldiv_s;
    logic               dec_illegal_s;
    logic [CODE_W-1:0]  ctrl_r;
    logic               muldiv_r;
    logic               illegal_r;

    alu_op_decode #(
        .EN_M (EN_M)
    ) u_dec (
        .ALUOp    (ALUOp),
        .funct3   (funct3),
        .opb5     (opb5),
        .funct7b5 (funct7b5),
        .funct7b0 (funct7b0),
        .ctrl     (dec_ctrl_s),
        .muldiv   (dec_muldiv_s),
        .illegal  (dec_illegal_s)
    );

    // A load of zero (single-cycle muldiv) skips WAIT entirely
    assign load_cnt_s   = !dec_muldiv_s ? CNT_ZERO : (funct3[2] ? DIV_LOAD : MUL_LOAD);
    assign load_state_s = (load_cnt_s == CNT_ZERO) ? ST_VALID : ST_WAIT;

    // Handshake FSM next-state, latency counter and in_ready
    always_comb begin
        state_nxt_s = state_r;
        count_nxt_s = count_r;
        in_ready_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = 1'b1;
                if (in_valid) begin
                    state_nxt_s = load_state_s;
                    count_nxt_s = load_cnt_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_r <= CNT_ONE) begin
                    state_nxt_s = ST_VALID;
                    count_nxt_s = CNT_ZERO;
                end else begin
                    count_nxt_s = count_r - CNT_ONE;
                end
            end
            ST_VALID: begin
                in_ready_s = out_ready;
                if (out_ready && in_valid) begin
                    state_nxt_s = load_state_s;
                    count_nxt_s = load_cnt_s;
                end else if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_VALID;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                count_nxt_s = CNT_ZERO;
            end
        endcase
    end

    assign accept_s = in_valid & in_ready_s;

    // State and counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
            count_r <= CNT_ZERO;
        end else begin
            state_r <= state_nxt_s;
            count_r <= count_nxt_s;
        end
    end

    // Output register captures the decode on accept only, so it holds while stalled
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_r    <= {CODE_W{1'b0}};
            muldiv_r  <= 1'b0;
            illegal_r <= 1'b0;
        end else if (accept_s) begin
            ctrl_r    <= dec_ctrl_s;
            muldiv_r  <= dec_muldiv_s;
            illegal_r <= dec_illegal_s;
        end else begin
            ctrl_r    <= ctrl_r;
            muldiv_r  <= muldiv_r;
            illegal_r <= illegal_r;
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = (state_r == ST_VALID);
    assign ALUControl = CTRL_W'(ctrl_r);
    assign MulDiv     = muldiv_r;
    assign illegal    = illegal_r;

endmodule

// File: tb/tb_alu_decode_seq.sv
// Self-checking bench: a timestamp-based reference model checked every cycle,
// plus directed vectors with hand-computed results and latencies.
module tb_alu_decode_seq;

    localparam int CW      = 5;
    localparam int MUL_LAT = 3;
    localparam int DIV_LAT = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, opb5, f7b5, f7b0, out_ready;
    logic [2:0]    funct3;
    logic [1:0]    aluop;
    logic          in_ready, out_valid, muldiv, illegal;
    logic [CW-1:0] aluctrl;
    logic          in_valid2, in_ready2, out_valid2, muldiv2, illegal2;
    logic [CW-1:0] aluctrl2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_decode_seq #(.CTRL_W(CW), .EN_M(1'b1), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opb5(opb5), .funct3(funct3), .funct7b5(f7b5), .funct7b0(f7b0), .ALUOp(aluop),
        .out_valid(out_valid), .out_ready(out_ready), .ALUControl(aluctrl),
        .MulDiv(muldiv), .illegal(illegal)
    );

    alu_decode_seq #(.CTRL_W(CW), .EN_M(1'b0), .MUL_CYCLES(MUL_LAT), .DIV_CYCLES(DIV_LAT)) dut_nom (
        .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
        .opb5(opb5), .funct3(funct3), .funct7b5(f7b5), .funct7b0(f7b0), .ALUOp(aluop),
        .out_valid(out_valid2), .out_ready(1'b1), .ALUControl(aluctrl2),
        .MulDiv(muldiv2), .illegal(illegal2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Result packed as {code[4:0], muldiv, illegal}, straight from the opcode table
    function automatic logic [6:0] ref_decode(input logic [1:0] op, input logic [2:0] f3,
                                              input logic r, input logic b5, input logic b0,
                                              input logic enm);
        logic [4:0] code;
        code = 5'd0;
        if (op == 2'b00) return 7'b0000000;
        if (op == 2'b11) return 7'b0000001;
        if (op == 2'b01) begin
            if (f3 == 3'd2 || f3 == 3'd3) return 7'b0000001;
            code = (f3 < 3'd4) ? 5'd1 : ((f3 < 3'd6) ? 5'd5 : 5'd6);
            return {code, 2'b00};
        end
        if (r && b0) return enm ? {2'b10, f3, 2'b10} : 7'b0000001;
        case (f3)
            3'd0:    code = (r && b5) ? 5'd1 : 5'd0;
            3'd1:    code = 5'd7;
            3'd2:    code = 5'd5;
            3'd3:    code = 5'd6;
            3'd4:    code = 5'd4;
            3'd5:    code = b5 ? 5'd9 : 5'd8;
            3'd6:    code = 5'd3;
            default: code = 5'd2;
        endcase
        return {code, 2'b00};
    endfunction

    // Reference model: one pending result, valid from its ready cycle until taken
    int         cyc   = 0;
    int         p_rdy = 0;
    bit         pend  = 1'b0;
    logic [6:0] p_res = 7'd0;
    logic [6:0] m_d;
    logic       m_v, m_r;

    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pend = 1'b0;
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_outputs", {25'd0, aluctrl, muldiv, illegal}, 32'd0);
        end else begin
            m_v = pend && (cyc >= p_rdy);
            m_r = !pend || (m_v && out_ready);
            check("out_valid", {31'd0, out_valid}, {31'd0, m_v});
            check("in_ready", {31'd0, in_ready}, {31'd0, m_r});
            if (m_v) check("result", {25'd0, aluctrl, muldiv, illegal}, {25'd0, p_res});
            if (m_v && out_ready) pend = 1'b0;
            if (in_valid && m_r) begin
                m_d   = ref_decode(aluop, funct3, opb5, f7b5, f7b0, 1'b1);
                pend  = 1'b1;
                p_res = m_d;
                p_rdy = cyc + (m_d[1] ? (m_d[4] ? DIV_LAT : MUL_LAT) : 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [1:0] op, input logic [2:0] f3,
                          input logic r, input logic b5, input logic b0);
        aluop = op; funct3 = f3; opb5 = r; f7b5 = b5; f7b0 = b0;
    endtask

    // Returns just after the accept edge with in_valid dropped
    task automatic issue(input logic [1:0] op, input logic [2:0] f3,
                         input logic r, input logic b5, input logic b0);
        int n = 0;
        set_op(op, f3, r, b5, b0);
        in_valid = 1'b1;
        #1;
        while (!in_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) check("issue_timeout", {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    // Latency counted with the accept edge as cycle 1
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            step();
            lat++;
        end
        if (!out_valid) check("wait_timeout", {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int nb;
        logic [7:0] vv;
        logic [2:0] b2b [4];
        b2b[0] = 3'b110; b2b[1] = 3'b100; b2b[2] = 3'b001; b2b[3] = 3'b011;

        reset = 1'b1; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        set_op(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        repeat (3) step();
        reset = 1'b0;
        step();
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);

        check("pin_sub", {25'd0, ref_decode(2'b10, 3'b000, 1'b1, 1'b1, 1'b0, 1'b1)}, 32'b0000001_00);
        check("pin_srai", {25'd0, ref_decode(2'b10, 3'b101, 1'b0, 1'b1, 1'b0, 1'b1)}, 32'b01001_00);
        check("pin_srli", {25'd0, ref_decode(2'b10, 3'b101, 1'b0, 1'b0, 1'b0, 1'b1)}, 32'b01000_00);
        check("pin_bltu", {25'd0, ref_decode(2'b01, 3'b110, 1'b0, 1'b0, 1'b0, 1'b1)}, 32'b00110_00);
        check("pin_br_ill", {25'd0, ref_decode(2'b01, 3'b010, 1'b0, 1'b0, 1'b0, 1'b1)}, 32'b00000_01);
        check("pin_div", {25'd0, ref_decode(2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1)}, 32'b10100_10);
        check("pin_div_nom", {25'd0, ref_decode(2'b10, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0)}, 32'b00000_01);

        issue(2'b10, 3'b000, 1'b1, 1'b1, 1'b0);
        wait_out(lat);
        check("sub_lat", lat, 32'd1);
        check("sub_ctrl", {27'd0, aluctrl}, 32'b00001);
        issue(2'b10, 3'b101, 1'b0, 1'b1, 1'b0);
        wait_out(lat);
        check("srai_ctrl", {27'd0, aluctrl}, 32'b01001);
        issue(2'b10, 3'b101, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        check("srli_ctrl", {27'd0, aluctrl}, 32'b01000);
        issue(2'b01, 3'b110, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        check("bltu_ctrl", {27'd0, aluctrl}, 32'b00110);
        issue(2'b01, 3'b010, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        check("br_ill", {26'd0, aluctrl, illegal}, 32'b000001);

        issue(2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        check("div_busy_in_ready", {31'd0, in_ready}, 32'd0);
        wait_out(lat);
        check("div_lat", lat, 32'd32);
        check("div_out", {25'd0, aluctrl, muldiv, illegal}, 32'b10100_10);
        issue(2'b10, 3'b000, 1'b1, 1'b0, 1'b1);
        wait_out(lat);
        check("mul_lat", lat, 32'd3);

        set_op(2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        check("nom_div", {24'd0, out_valid2, aluctrl2, muldiv2, illegal2}, 32'b1_00000_01);
        step(); step();

        out_ready = 1'b0;
        issue(2'b00, 3'b111, 1'b1, 1'b0, 1'b0);
        set_op(2'b10, 3'b111, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1;
        repeat (5) step();
        check("stall_hold", {25'd0, out_valid, in_ready, aluctrl}, 32'b1_0_00000);
        out_ready = 1'b1;
        step();
        check("b2b_and", {27'd0, aluctrl}, 32'b00010);
        nb = 0;
        for (int i = 0; i < 4; i++) begin
            funct3 = b2b[i];
            step();
            if (out_valid) nb++;
        end
        in_valid = 1'b0;
        check("b2b_count", nb, 32'd4);
        check("b2b_last", {27'd0, aluctrl}, 32'b00110);
        step();
        check("b2b_drain", {31'd0, out_valid}, 32'd0);

        issue(2'b10, 3'b100, 1'b1, 1'b0, 1'b1);
        repeat (21) step();
        reset = 1'b1;
        #1;
        check("rst_mid_div", {31'd0, out_valid}, 32'd0);
        step();
        reset = 1'b0;
        issue(2'b00, 3'b000, 1'b0, 1'b0, 1'b0);
        wait_out(lat);
        check("post_rst_add_lat", lat, 32'd1);
        check("post_rst_add", {25'd0, aluctrl, muldiv, illegal}, 32'd0);
        step();

        for (int v = 0; v < 256; v++) begin
            vv = v[7:0];
            if (vv[1:0] == 2'b11) begin
                out_ready = 1'b0;
                step(); step();
                out_ready = 1'b1;
            end
            issue(vv[7:6], vv[5:3], vv[2], vv[1], vv[0]);
        end
        repeat (40) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
